// File: rtl/clock_switch_ctrl.sv
// Sequencer for the glitch-free HS/LS CPU clock switch: drives the switch select,
// follows its synchronised status, and adds LS dwell hysteresis, timeout and an event count.
module clock_switch_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int LS_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       hs_ck_ip,
  input  logic       resetb,
  input  logic       slow_req_ip,
  input  logic       force_ls_ip,
  input  logic       err_clr_ip,
  input  logic       selected_hs_ip,
  input  logic       selected_ls_ip,
  output logic       select_hs_op,
  output logic       on_hs_op,
  output logic       busy_op,
  output logic       err_op,
  output logic [7:0] switch_cnt_op
);

  localparam logic [1:0] LS_RUN = 2'd0;
  localparam logic [1:0] TO_HS  = 2'd1;
  localparam logic [1:0] HS_RUN = 2'd2;
  localparam logic [1:0] TO_LS  = 2'd3;

  localparam int HOLD_W = (LS_HOLD_CYCLES > 0) ? $clog2(LS_HOLD_CYCLES + 1) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LS_HOLD_CYCLES);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  // Status synchronisers: stage 0 samples the async switch status.
  logic [SYNC_STAGES-1:0] hs_sync_reg, hs_sync_next;
  logic [SYNC_STAGES-1:0] ls_sync_reg, ls_sync_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign hs_sync_next[gi] = selected_hs_ip;
        assign ls_sync_next[gi] = selected_ls_ip;
      end else begin : g_tail
        assign hs_sync_next[gi] = hs_sync_reg[gi-1];
        assign ls_sync_next[gi] = ls_sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge hs_ck_ip or negedge resetb) begin
    if (!resetb) begin
      hs_sync_reg <= '0;
      ls_sync_reg <= '0;
    end else begin
      hs_sync_reg <= hs_sync_next;
      ls_sync_reg <= ls_sync_next;
    end
  end

  logic s_hs, s_ls, want_hs, hs_ok, ls_ok;
  assign s_hs    = hs_sync_reg[SYNC_STAGES-1];
  assign s_ls    = ls_sync_reg[SYNC_STAGES-1];
  assign want_hs = ~slow_req_ip & ~force_ls_ip;
  assign hs_ok   = s_hs & ~s_ls;
  assign ls_ok   = s_ls & ~s_hs;

  logic [1:0]        state_reg, state_next;
  logic              select_reg, select_next;
  logic [HOLD_W-1:0] hold_reg, hold_next, hold_dec;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next, to_inc;
  logic              to_hit;
  logic [7:0]        sw_cnt_reg, sw_cnt_next;
  logic              err_reg, err_next, err_set;
  logic              on_hs_reg, busy_reg;

  assign hold_dec = (hold_reg == '0) ? '0 : hold_reg - 1'b1;
  assign to_inc   = (to_cnt_reg == TO_MAX) ? TO_MAX : to_cnt_reg + 1'b1;
  assign to_hit   = (to_cnt_reg != TO_MAX) && (to_inc == TO_MAX);

  always_comb begin
    state_next  = state_reg;
    select_next = select_reg;
    hold_next   = hold_reg;
    to_cnt_next = to_cnt_reg;
    sw_cnt_next = sw_cnt_reg;
    err_set     = 1'b0;
    case (state_reg)
      LS_RUN: begin
        // Switch on the cycle the hold expires, so LS_RUN lasts exactly the hold time.
        hold_next = hold_dec;
        if ((hold_dec == '0) && want_hs) begin
          state_next  = TO_HS;
          select_next = 1'b1;
          to_cnt_next = '0;
        end
      end
      TO_HS: begin
        to_cnt_next = to_inc;
        err_set     = to_hit;
        if (hs_ok) begin
          state_next  = HS_RUN;
          sw_cnt_next = sw_cnt_reg + 8'd1;
        end
      end
      HS_RUN: begin
        if (!want_hs) begin
          state_next  = TO_LS;
          select_next = 1'b0;
          to_cnt_next = '0;
        end
      end
      default: begin
        to_cnt_next = to_inc;
        err_set     = to_hit;
        if (ls_ok) begin
          state_next  = LS_RUN;
          hold_next   = HOLD_INIT;
          sw_cnt_next = sw_cnt_reg + 8'd1;
        end
      end
    endcase
    // A timeout in the same cycle as a clear keeps the flag set.
    err_next = err_set | (err_reg & ~err_clr_ip);
  end

  always_ff @(posedge hs_ck_ip or negedge resetb) begin
    if (!resetb) begin
      state_reg  <= LS_RUN;
      select_reg <= 1'b0;
      hold_reg   <= HOLD_INIT;
      to_cnt_reg <= '0;
      sw_cnt_reg <= 8'd0;
      err_reg    <= 1'b0;
      on_hs_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      select_reg <= select_next;
      hold_reg   <= hold_next;
      to_cnt_reg <= to_cnt_next;
      sw_cnt_reg <= sw_cnt_next;
      err_reg    <= err_next;
      on_hs_reg  <= (state_next == HS_RUN);
      busy_reg   <= (state_next == TO_HS) || (state_next == TO_LS);
    end
  end

  assign select_hs_op  = select_reg;
  assign on_hs_op      = on_hs_reg;
  assign busy_op       = busy_reg;
  assign err_op        = err_reg;
  assign switch_cnt_op = sw_cnt_reg;

endmodule
